// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory port between
// instruction fetch and data load/store, with per-stage stall outputs.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_en,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata
);

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [3:0] CNT_LOAD  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        m_en_q, m_en_d;
  logic        m_we_q, m_we_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [15:0] m_wdata_q, m_wdata_d;
  logic        pick_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    m_en_d       = 1'b0;
    m_we_d       = 1'b0;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    pick_data    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On a tie the side that was not served last wins.
          pick_data = d_req && (!if_req || (last_grant_q == OWN_FETCH));
          owner_d   = pick_data ? OWN_DATA : OWN_FETCH;
          we_d      = pick_data && d_we;
          m_addr_d  = pick_data ? d_addr : {8'h00, if_addr};
          if (pick_data) begin
            m_wdata_d = d_wdata;
          end
          // Strobe is registered here so it is high during the ISSUE cycle.
          m_en_d  = 1'b1;
          m_we_d  = pick_data && d_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // This is cycle ISSUE+MEM_LAT: read data is valid on m_rdata now.
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = m_rdata;
            if_ack_d   = 1'b1;
          end else begin
            if (!we_q) begin
              d_rdata_d = m_rdata;
            end
            d_ack_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      last_grant_q <= OWN_FETCH;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= 16'h0000;
      d_rdata_q    <= 16'h0000;
      m_en_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 16'h0000;
      m_wdata_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      m_en_q       <= m_en_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-schedule model predicts
// every output cycle by cycle; a second MEM_LAT=1 instance gets a directed load.
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr;
  logic [15:0] d_addr, d_wdata, m_rdata;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, stall_if, stall_mem, m_en, m_we;

  logic        if_req_1, d_req_1, d_we_1;
  logic [7:0]  if_addr_1;
  logic [15:0] d_addr_1, d_wdata_1, m_rdata_1;
  logic [15:0] if_rdata_1, d_rdata_1, m_addr_1, m_wdata_1;
  logic        if_ack_1, d_ack_1, stall_if_1, stall_mem_1, m_en_1, m_we_1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ack(if_ack_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_rdata(d_rdata_1), .d_ack(d_ack_1),
    .stall_if(stall_if_1), .stall_mem(stall_mem_1),
    .m_en(m_en_1), .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
    .m_rdata(m_rdata_1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Transaction schedule model: a grant sampled in cycle s issues in s+1,
  // acks in s+2+L, and the arbiter can sample again in s+3+L.
  bit          txn_v, txn_data, txn_we;
  logic [15:0] txn_addr, txn_wdata;
  int          t_issue, t_ack, next_free;
  bit          last_data;
  logic [15:0] exp_if_rdata, exp_d_rdata, exp_m_addr;
  bit          if_pend, d_pend, rst_prev;
  int          rr_if_cnt, rr_d_cnt;

  // Memory stand-in reacting to the DUT strobe; garbage outside the valid cycle.
  bit          mem_pend, mem_we_p;
  int          mem_due;
  logic [15:0] mem_addr_p;

  initial begin
    bit exp_m_en, exp_if_ack, exp_d_ack, pick_d, rr_phase;
    int p_req, rr_diff;

    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    if_req_1 = 0; if_addr_1 = 0; d_req_1 = 0; d_we_1 = 0; d_addr_1 = 0; d_wdata_1 = 0;
    m_rdata_1 = 0;
    txn_v = 0; next_free = 0; last_data = 0;
    exp_if_rdata = 0; exp_d_rdata = 0; exp_m_addr = 0;
    if_pend = 0; d_pend = 0; rst_prev = 1; mem_pend = 0;
    rr_if_cnt = 0; rr_d_cnt = 0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rr_phase = (cyc >= 60 && cyc < 300);
      p_req    = rr_phase ? 100 : ((cyc < 60) ? 10 : 35);
      rst = (cyc < 2) || (cyc == 150) || (cyc >= 300 && $urandom_range(0, 127) == 0);

      if (rst) begin
        if_req = 1'($urandom); if_addr = 8'($urandom);
        d_req = 1'($urandom); d_we = 1'($urandom);
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end else begin
        if (!if_pend) begin
          if ($urandom_range(0, 99) < p_req) begin
            if_pend = 1; if_req = 1; if_addr = 8'($urandom);
          end else begin
            if_req = 0;
          end
        end else if (!rr_phase && txn_v && !txn_data && $urandom_range(0, 15) == 0) begin
          if_req = 0;
        end
        if (!d_pend) begin
          if ($urandom_range(0, 99) < p_req) begin
            d_pend = 1; d_req = 1; d_we = 1'($urandom);
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
          end else begin
            d_req = 0;
          end
        end else if (!rr_phase && txn_v && txn_data && $urandom_range(0, 15) == 0) begin
          d_req = 0;
        end
      end

      if (mem_pend && mem_due == cyc) begin
        m_rdata  = mem_we_p ? 16'($urandom) : memval(mem_addr_p);
        mem_pend = 0;
      end else begin
        m_rdata = 16'($urandom);
      end
      if (m_en === 1'b1) begin
        mem_pend = 1; mem_due = cyc + L; mem_addr_p = m_addr; mem_we_p = m_we;
      end
      #1;

      exp_m_en   = txn_v && (cyc == t_issue);
      exp_if_ack = txn_v && !txn_data && (cyc == t_ack);
      exp_d_ack  = txn_v && txn_data && (cyc == t_ack);
      if (exp_m_en) exp_m_addr = txn_addr;
      if (exp_if_ack) exp_if_rdata = memval(txn_addr);
      if (exp_d_ack && !txn_we) exp_d_rdata = memval(txn_addr);

      check_val("m_en", m_en, exp_m_en);
      check_val("m_we", m_we, exp_m_en && txn_we);
      check_val("m_addr", m_addr, exp_m_addr);
      if (exp_m_en && txn_we) check_val("m_wdata", m_wdata, txn_wdata);
      if (rst_prev) check_val("m_wdata_rst", m_wdata, 16'h0000);
      check_val("if_ack", if_ack, exp_if_ack);
      check_val("d_ack", d_ack, exp_d_ack);
      check_val("if_rdata", if_rdata, exp_if_rdata);
      check_val("d_rdata", d_rdata, exp_d_rdata);
      check_val("stall_if", stall_if, if_req && !exp_if_ack);
      check_val("stall_mem", stall_mem, d_req && !exp_d_ack);

      if (exp_if_ack || exp_d_ack) begin
        $display("txn cyc=%0d %s addr=%h we=%0d", cyc, txn_data ? "data " : "fetch",
                 txn_addr, txn_we);
        last_data = txn_data;
        if (txn_data) d_pend = 0; else if_pend = 0;
        if (rr_phase) begin
          if (txn_data) rr_d_cnt++; else rr_if_cnt++;
        end
        txn_v = 0;
      end

      if (rst) begin
        txn_v = 0; if_pend = 0; d_pend = 0; last_data = 0; next_free = cyc + 1;
        exp_if_rdata = 0; exp_d_rdata = 0; exp_m_addr = 0;
      end else if (!txn_v && cyc >= next_free && (if_req || d_req)) begin
        pick_d    = d_req && (!if_req || !last_data);
        txn_data  = pick_d;
        txn_we    = pick_d && d_we;
        txn_addr  = pick_d ? d_addr : {8'h00, if_addr};
        txn_wdata = d_wdata;
        t_issue   = cyc + 1;
        t_ack     = cyc + 2 + L;
        next_free = cyc + 3 + L;
        txn_v     = 1;
      end
      rst_prev = rst;
    end

    rr_diff = rr_d_cnt - rr_if_cnt;
    check_val("rr_balance", 16'((rr_diff <= 2) && (rr_diff >= -2)), 16'd1);
    check_val("rr_no_starve", 16'((rr_d_cnt > 0) && (rr_if_cnt > 0)), 16'd1);

    // MEM_LAT=1 instance: a single load issued in cycle 1, data in cycle 2, ack in 3.
    @(negedge clk);
    rst = 0; if_req = 0; d_req = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      d_req_1 = (c <= 3); d_we_1 = 0; d_addr_1 = 16'h1357; d_wdata_1 = 16'hAAAA;
      m_rdata_1 = (c == 2) ? memval(16'h1357) : 16'($urandom);
      #1;
      check_val("lat1_m_en", m_en_1, c == 1);
      check_val("lat1_d_ack", d_ack_1, c == 3);
      if (c == 1) check_val("lat1_m_addr", m_addr_1, 16'h1357);
      if (c == 3) check_val("lat1_d_rdata", d_rdata_1, memval(16'h1357));
    end
    $display("txn lat1 load addr=1357 done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the 16-bit pipelined CPU. It shares one backing memory between the fetch stage (instruction reads) and the memory stage (data loads and stores). Conflicts are resolved with round-robin priority, and each access is sequenced through a fixed-latency memory protocol. The block drives per-stage stall signals so the pipeline holds until its access completes.

## Interface
- MEM_LAT, 2, memory read latency in cycles from the m_en cycle to valid m_rdata; legal range 1..15
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  8  fetch address (instruction memory space is 8-bit)
- if_rdata  out  16  fetched instruction; valid when if_ack=1, holds until the next fetch ack
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_rdata  out  16  load data; valid when d_ack=1 after a load, holds otherwise
- d_ack  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- m_en  out  1  memory access strobe, high exactly one cycle per access
- m_we  out  1  memory write enable; only high together with m_en
- m_addr  out  16  memory address; fetch addresses are zero-extended
- m_wdata  out  16  memory write data
- m_rdata  in  16  memory read data, valid in cycle c+MEM_LAT when m_en is high in cycle c

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - if no request is pending, stay in IDLE.
  - otherwise select an owner:
    - only one requester active → that requester wins.
    - both active → the requester not granted last wins.
  - latch the owner, address, we and wdata into registers, then go to ISSUE.
- ISSUE:
  - drive m_en=1 and m_we=latched we, plus m_addr/m_wdata from the latched values.
  - load the counter with MEM_LAT-1.
  - if MEM_LAT=1, go to RESP; otherwise go to WAIT.
- WAIT:
  - decrement the counter.
  - when it reaches 1, capture m_rdata at the end of the current cycle (the cycle ISSUE+MEM_LAT) and go to RESP.
  - with MEM_LAT=1, the capture happens at the end of ISSUE+1, entered as WAIT-equivalent; the implementation must capture m_rdata in cycle ISSUE+MEM_LAT in all cases.
- RESP:
  - pulse the owner's ack.
  - update the owner's rdata register, except on stores, where d_rdata is unchanged.
  - set last_grant to the owner, then go to IDLE.
  - requests are not sampled in RESP.
- Stores use identical timing to loads; m_rdata is ignored for stores.
- Fetches never assert m_we.
- last_grant resets to FETCH, so the first tie goes to data.
- If a requester drops its req mid-transaction, the access still completes and ack still pulses.
- Outputs m_addr and m_wdata hold their last values outside ISSUE; m_we=0 whenever m_en=0.

## Timing
- Reset values: if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, state=IDLE, last_grant=FETCH.
- Reset mid-operation abandons the in-flight access: no ack is produced, and m_en is 0 from the next cycle.
- Latency for a request first seen in an IDLE cycle t:
  - m_en high in t+1.
  - data captured in t+1+MEM_LAT.
  - ack high in t+2+MEM_LAT.
- Back-to-back throughput is one access per MEM_LAT+3 cycles: ack cycle, then IDLE, then ISSUE.
- The counter is 4 bits and never wraps, given the legal MEM_LAT range.
- The stall signals fall in the same cycle the ack rises.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all outputs 0; stall_if follows if_req.
- Single fetch (MEM_LAT=2): if_req=1, if_addr=8'h05 from cycle 0, m_rdata=16'h1234 in cycle 3:
  - m_en=1, m_we=0, m_addr=16'h0005 in cycle 1.
  - if_ack=1, if_rdata=16'h1234 in cycle 4.
  - stall_if=1 in cycles 0–3, 0 in cycle 4.
- Store: d_req=1, d_we=1, d_addr=16'h0040, d_wdata=16'hBEEF at cycle 0:
  - cycle 1: m_en=1, m_we=1, m_addr=16'h0040, m_wdata=16'hBEEF.
  - d_ack in cycle 4.
  - d_rdata unchanged.
- Tie after reset: both requests raised at cycle 0:
  - data wins: m_addr=d_addr in cycle 1, d_ack in cycle 4.
  - fetch: m_en in cycle 6, if_ack in cycle 9.
- Round-robin: both requests held continuously → grant order D, I, D, I with acks at cycles 4, 9, 14, 19; neither requester is starved.
- Reset mid-access: rst=1 in cycle 2 of a fetch → no if_ack ever appears; m_en=0 in cycle 3; the next tie is granted to data.
- MEM_LAT=1 build: single load → m_en in cycle 1, m_rdata sampled in cycle 2, d_ack in cycle 3.
